// File: rtl/score_pkg.sv
// Shared definitions for the scoring path: capture/stream feeder and evaluate.
package score_pkg;

   localparam int DATA_W_DEF    = 16;
   localparam int FRAME_LEN_DEF = 256;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PREP   = 2'd1,
      S_STREAM = 2'd2,
      S_WAIT   = 2'd3
   } stream_state_t;

   typedef logic [DATA_W_DEF-1:0] sample_t;

endpackage

// File: rtl/score_frame_bank_ram.sv
// Ping-pong frame store: two banks of FRAME_LEN sample pairs, addressed by
// {bank, index}. Each word is split into a base lane and a test lane with
// their own write enable and write index, because the two channels fill at
// independent rates. The read returns both lanes together, one cycle late.
module frame_bank_ram
   import score_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_wr_en_base,
   input  logic [$clog2(FRAME_LEN):0]     i_wr_addr_base,
   input  logic [DATA_W-1:0]              i_wr_data_base,
   input  logic                           i_wr_en_test,
   input  logic [$clog2(FRAME_LEN):0]     i_wr_addr_test,
   input  logic [DATA_W-1:0]              i_wr_data_test,
   input  logic                           i_rd_en,
   input  logic [$clog2(FRAME_LEN):0]     i_rd_addr,
   output logic [DATA_W-1:0]              o_rd_data_base,
   output logic [DATA_W-1:0]              o_rd_data_test
);

   localparam int DEPTH = 2 * FRAME_LEN;

   logic [DATA_W-1:0] r_mem_base [0:DEPTH-1];
   logic [DATA_W-1:0] r_mem_test [0:DEPTH-1];
   logic [DATA_W-1:0] r_rd_base;
   logic [DATA_W-1:0] r_rd_test;

   // Lane writes; no reset on the array so it maps onto block RAM.
   always_ff @(posedge i_clk) begin
      if (i_wr_en_base) begin
         r_mem_base[i_wr_addr_base] <= i_wr_data_base;
      end
      if (i_wr_en_test) begin
         r_mem_test[i_wr_addr_test] <= i_wr_data_test;
      end
   end

   // Registered read; the output returns to zero whenever no read is issued,
   // which keeps the streamed samples at zero outside a frame.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_base <= '0;
         r_rd_test <= '0;
      end else if (i_rd_en) begin
         r_rd_base <= r_mem_base[i_rd_addr];
         r_rd_test <= r_mem_test[i_rd_addr];
      end else begin
         r_rd_base <= '0;
         r_rd_test <= '0;
      end
   end

   assign o_rd_data_base = r_rd_base;
   assign o_rd_data_test = r_rd_test;

endmodule

// File: rtl/score_frame_feeder.sv
// Capture-and-stream stage ahead of the evaluator. Base and test samples fill
// a ping-pong pair of frame banks; a complete bank is streamed one sample
// pair per clock, then the feeder waits for the evaluator verdict and
// accumulates frame and hit counts.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for the read bank to become full
// S_PREP   | read address 0 issued, RAM data arrives next cycle
// S_STREAM | presenting sample r_idx, prefetching r_idx+1
// S_WAIT   | frame sent, waiting for evaluator finish to release bank
module score_frame_feeder
   import score_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int CNT_W     = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_enable,
   input  logic              i_base_valid,
   input  logic [DATA_W-1:0] i_base_data,
   input  logic              i_test_valid,
   input  logic [DATA_W-1:0] i_test_data,
   output logic              o_start,
   output logic              o_stream_valid,
   output logic [DATA_W-1:0] o_signal_base,
   output logic [DATA_W-1:0] o_signal_test,
   input  logic              i_eval_finish,
   input  logic              i_eval_result,
   output logic [CNT_W-1:0]  o_frame_cnt,
   output logic [CNT_W-1:0]  o_hit_cnt,
   output logic              o_overflow,
   output logic              o_busy
);

   localparam int                IDX_W    = $clog2(FRAME_LEN);
   localparam int                PTR_W    = IDX_W + 1;
   localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(FRAME_LEN);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   // capture side
   logic             r_wr_bank;
   logic [1:0]       r_full;
   logic [PTR_W-1:0] r_base_ptr;
   logic [PTR_W-1:0] r_test_ptr;
   logic             r_overflow;

   // stream side
   stream_state_t    r_state;
   logic             r_rd_bank;
   logic [IDX_W-1:0] r_idx;
   logic             r_start;
   logic             r_stream_valid;
   logic [CNT_W-1:0] r_frame_cnt;
   logic [CNT_W-1:0] r_hit_cnt;

   logic             w_wr_blocked;
   logic             w_base_acc;
   logic             w_test_acc;
   logic             w_drop;
   logic [PTR_W-1:0] w_base_ptr_nxt;
   logic [PTR_W-1:0] w_test_ptr_nxt;
   logic             w_frame_done;
   logic             w_release;
   logic             w_rd_en;
   logic [IDX_W-1:0] w_rd_idx;
   logic [DATA_W-1:0] w_rd_base;
   logic [DATA_W-1:0] w_rd_test;

   // A channel accepts while its pointer has room and the write bank is free;
   // a valid that arrives while enabled but cannot be accepted is an overflow.
   assign w_wr_blocked   = r_full[r_wr_bank];
   assign w_base_acc     = i_enable && i_base_valid && !w_wr_blocked && (r_base_ptr != PTR_FULL);
   assign w_test_acc     = i_enable && i_test_valid && !w_wr_blocked && (r_test_ptr != PTR_FULL);
   assign w_drop         = i_enable && ((i_base_valid && !w_base_acc) || (i_test_valid && !w_test_acc));
   assign w_base_ptr_nxt = r_base_ptr + PTR_W'(w_base_acc);
   assign w_test_ptr_nxt = r_test_ptr + PTR_W'(w_test_acc);
   // The completing sample closes the bank on the same edge that writes it.
   assign w_frame_done   = (w_base_ptr_nxt == PTR_FULL) && (w_test_ptr_nxt == PTR_FULL);
   assign w_release      = (r_state == S_WAIT) && i_eval_finish;

   // Capture pointers, bank flags and sticky overflow. The set of full[wr_bank]
   // and the clear of full[rd_bank] can never hit the same flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_bank  <= 1'b0;
         r_full     <= 2'b00;
         r_base_ptr <= '0;
         r_test_ptr <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_frame_done) begin
            r_full[r_wr_bank] <= 1'b1;
            r_wr_bank         <= ~r_wr_bank;
            r_base_ptr        <= '0;
            r_test_ptr        <= '0;
         end else begin
            r_base_ptr <= w_base_ptr_nxt;
            r_test_ptr <= w_test_ptr_nxt;
         end
         if (w_release) begin
            r_full[r_rd_bank] <= 1'b0;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Read address issue: index 0 in S_PREP, then one ahead of the presented
   // sample during S_STREAM, stopping after the last sample is fetched.
   always_comb begin
      w_rd_en  = 1'b0;
      w_rd_idx = '0;
      case (r_state)
         S_PREP: begin
            w_rd_en = 1'b1;
         end
         S_STREAM: begin
            if (r_idx != IDX_LAST) begin
               w_rd_en  = 1'b1;
               w_rd_idx = r_idx + IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   frame_bank_ram #(
      .DATA_W    (DATA_W),
      .FRAME_LEN (FRAME_LEN)
   ) u_ram (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_wr_en_base   (w_base_acc),
      .i_wr_addr_base ({r_wr_bank, r_base_ptr[IDX_W-1:0]}),
      .i_wr_data_base (i_base_data),
      .i_wr_en_test   (w_test_acc),
      .i_wr_addr_test ({r_wr_bank, r_test_ptr[IDX_W-1:0]}),
      .i_wr_data_test (i_test_data),
      .i_rd_en        (w_rd_en),
      .i_rd_addr      ({r_rd_bank, w_rd_idx}),
      .o_rd_data_base (w_rd_base),
      .o_rd_data_test (w_rd_test)
   );

   // Stream FSM with registered start/valid and saturating result counters.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state        <= S_IDLE;
         r_rd_bank      <= 1'b0;
         r_idx          <= '0;
         r_start        <= 1'b0;
         r_stream_valid <= 1'b0;
         r_frame_cnt    <= '0;
         r_hit_cnt      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_start        <= 1'b0;
               r_stream_valid <= 1'b0;
               if (r_full[r_rd_bank]) begin
                  r_state <= S_PREP;
               end
            end
            S_PREP: begin
               r_idx          <= '0;
               r_start        <= 1'b1;
               r_stream_valid <= 1'b1;
               r_state        <= S_STREAM;
            end
            S_STREAM: begin
               r_start <= 1'b0;
               if (r_idx == IDX_LAST) begin
                  r_stream_valid <= 1'b0;
                  r_state        <= S_WAIT;
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            S_WAIT: begin
               r_start        <= 1'b0;
               r_stream_valid <= 1'b0;
               if (i_eval_finish) begin
                  if (r_frame_cnt != CNT_MAX) begin
                     r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                  end
                  if (i_eval_result && (r_hit_cnt != CNT_MAX)) begin
                     r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                  end
                  r_rd_bank <= ~r_rd_bank;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_start        = r_start;
   assign o_stream_valid = r_stream_valid;
   assign o_signal_base  = w_rd_base;
   assign o_signal_test  = w_rd_test;
   assign o_frame_cnt    = r_frame_cnt;
   assign o_hit_cnt      = r_hit_cnt;
   assign o_overflow     = r_overflow;
   assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_score_frame_feeder.sv
// Directed bench for score_frame_feeder: full-size instance for frame flow,
// plus a tiny-frame, 2-bit-counter instance for counter saturation.
module tb_score_frame_feeder;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_enable;
   logic        i_base_valid, i_test_valid;
   logic [15:0] i_base_data, i_test_data;
   logic        i_eval_finish, i_eval_result;
   logic        o_start, o_stream_valid, o_overflow, o_busy;
   logic [15:0] o_signal_base, o_signal_test, o_frame_cnt, o_hit_cnt;

   logic        s_bv, s_tv, s_fin, s_res;
   logic [15:0] s_bd, s_td;
   logic        s_start, s_valid, s_ovf, s_busy;
   logic [15:0] s_sig_base, s_sig_test;
   logic [1:0]  s_frame_cnt, s_hit_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 i_clk = ~i_clk;

   score_frame_feeder u_dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_enable       (i_enable),
      .i_base_valid   (i_base_valid),
      .i_base_data    (i_base_data),
      .i_test_valid   (i_test_valid),
      .i_test_data    (i_test_data),
      .o_start        (o_start),
      .o_stream_valid (o_stream_valid),
      .o_signal_base  (o_signal_base),
      .o_signal_test  (o_signal_test),
      .i_eval_finish  (i_eval_finish),
      .i_eval_result  (i_eval_result),
      .o_frame_cnt    (o_frame_cnt),
      .o_hit_cnt      (o_hit_cnt),
      .o_overflow     (o_overflow),
      .o_busy         (o_busy)
   );

   score_frame_feeder #(.DATA_W(16), .FRAME_LEN(4), .CNT_W(2)) u_small (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_enable       (i_enable),
      .i_base_valid   (s_bv),
      .i_base_data    (s_bd),
      .i_test_valid   (s_tv),
      .i_test_data    (s_td),
      .o_start        (s_start),
      .o_stream_valid (s_valid),
      .o_signal_base  (s_sig_base),
      .o_signal_test  (s_sig_test),
      .i_eval_finish  (s_fin),
      .i_eval_result  (s_res),
      .o_frame_cnt    (s_frame_cnt),
      .o_hit_cnt      (s_hit_cnt),
      .o_overflow     (s_ovf),
      .o_busy         (s_busy)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic bv, input int bd, input logic tv, input int td);
      i_base_valid = bv;
      i_base_data  = 16'(bd);
      i_test_valid = tv;
      i_test_data  = 16'(td);
      tick();
      i_base_valid = 1'b0;
      i_test_valid = 1'b0;
   endtask

   task automatic feed_pairs(input int bo, input int to, input int cnt);
      for (int n = 0; n < cnt; n++) drive(1'b1, bo + n, 1'b1, to + n);
   endtask

   task automatic finish_eval(input logic res);
      i_eval_finish = 1'b1;
      i_eval_result = res;
      tick();
      i_eval_finish = 1'b0;
      i_eval_result = 1'b0;
   endtask

   // Waits (bounded) for o_start, then checks 256 gap-free cycles of data.
   task automatic stream_check(input string tag, input int bo, input int to);
      int t   = 0;
      int bad = 0;
      while (o_start !== 1'b1 && t < 2000) begin
         tick();
         t++;
      end
      chk({tag, "_start"}, 32'(o_start), 1);
      for (int k = 0; k < 256; k++) begin
         if (o_stream_valid !== 1'b1 || o_start !== (k == 0) ||
             o_signal_base !== 16'(bo + k) || o_signal_test !== 16'(to + k)) bad++;
         tick();
      end
      chk({tag, "_data_errs"}, 32'(bad), 0);
      chk({tag, "_end"}, {15'd0, o_stream_valid, o_signal_base}, 0);
   endtask

   initial begin
      int t;
      int starts;
      i_rst = 1'b0;
      i_enable = 1'b1;
      i_base_valid = 1'b0; i_test_valid = 1'b0;
      i_base_data = '0; i_test_data = '0;
      i_eval_finish = 1'b0; i_eval_result = 1'b0;
      s_bv = 1'b0; s_tv = 1'b0; s_bd = '0; s_td = '0; s_fin = 1'b0; s_res = 1'b0;
      #1 i_rst = 1'b1;
      repeat (3) tick();

      chk("rst_ctl", {28'd0, o_start, o_stream_valid, o_overflow, o_busy}, 0);
      chk("rst_sig", {o_signal_base, o_signal_test}, 0);
      chk("rst_cnt", {o_frame_cnt, o_hit_cnt}, 0);
      i_rst = 1'b0;
      tick();

      // single frame, exact capture-to-start latency
      feed_pairs(0, 1000, 256);
      tick();
      chk("single_prep_start", 32'(o_start), 0);
      chk("single_prep_busy", 32'(o_busy), 1);
      tick();
      chk("single_start_lat", 32'(o_start), 1);
      stream_check("single", 0, 1000);
      chk("single_wait_busy", 32'(o_busy), 1);
      chk("single_cnt_pre", 32'(o_frame_cnt), 0);
      finish_eval(1'b1);
      chk("single_frame_cnt", 32'(o_frame_cnt), 1);
      chk("single_hit_cnt", 32'(o_hit_cnt), 1);
      chk("single_idle", 32'(o_busy), 0);

      // skewed channels
      for (int n = 0; n < 256; n++) drive(1'b1, 2000 + n, 1'b0, 0);
      repeat (100) tick();
      chk("skew_no_start", 32'(o_busy), 0);
      for (int n = 0; n < 256; n++) drive(1'b0, 0, 1'b1, 3000 + n);
      stream_check("skew", 2000, 3000);
      chk("skew_ovf", 32'(o_overflow), 0);
      finish_eval(1'b0);
      chk("skew_cnts", {o_frame_cnt, o_hit_cnt}, {16'd2, 16'd1});

      // ping-pong: frame B captured while A streams and waits
      fork
         begin
            feed_pairs(4000, 5000, 256);
            feed_pairs(6000, 7000, 256);
         end
         stream_check("pp_a", 4000, 5000);
      join
      chk("pp_ovf", 32'(o_overflow), 0);
      chk("pp_wait", 32'(o_busy), 1);
      finish_eval(1'b0);
      tick();
      chk("pp_b_prep", 32'(o_start), 0);
      tick();
      chk("pp_b_start_lat", 32'(o_start), 1);
      stream_check("pp_b", 6000, 7000);
      finish_eval(1'b1);
      chk("pp_cnts", {o_frame_cnt, o_hit_cnt}, {16'd4, 16'd2});

      // overflow: both banks full, extra samples dropped
      feed_pairs(8000, 9000, 256);
      feed_pairs(10000, 11000, 256);
      chk("ovf_before", 32'(o_overflow), 0);
      feed_pairs(16'hAAAA, 16'h5555, 5);
      chk("ovf_set", 32'(o_overflow), 1);
      repeat (4) tick();
      finish_eval(1'b1);
      stream_check("ovf_d", 10000, 11000);
      chk("ovf_sticky", 32'(o_overflow), 1);
      finish_eval(1'b0);
      chk("ovf_cnts", {o_frame_cnt, o_hit_cnt}, {16'd6, 16'd3});

      // reset at stream sample 100
      feed_pairs(12000, 13000, 256);
      t = 0;
      while (o_start !== 1'b1 && t < 20) begin tick(); t++; end
      chk("rstmid_start", 32'(o_start), 1);
      repeat (100) tick();
      chk("rstmid_sample100", 32'(o_signal_base), 12100);
      i_rst = 1'b1;
      #1;
      chk("rstmid_ctl", {28'd0, o_start, o_stream_valid, o_overflow, o_busy}, 0);
      chk("rstmid_sig", {o_signal_base, o_signal_test}, 0);
      chk("rstmid_cnt", {o_frame_cnt, o_hit_cnt}, 0);
      tick();
      i_rst = 1'b0;
      starts = 0;
      for (int c = 0; c < 300; c++) begin
         if (o_start === 1'b1 || o_busy === 1'b1) starts++;
         tick();
      end
      chk("rstmid_no_restart", 32'(starts), 0);

      // enable low ignores valids; stray finish in idle ignored
      i_enable = 1'b0;
      feed_pairs(1, 1, 10);
      i_enable = 1'b1;
      chk("en_low_ovf", 32'(o_overflow), 0);
      chk("en_low_busy", 32'(o_busy), 0);
      finish_eval(1'b1);
      chk("stray_finish", {o_frame_cnt, o_hit_cnt}, 0);
      feed_pairs(14000, 15000, 256);
      stream_check("post_rst", 14000, 15000);
      finish_eval(1'b1);
      chk("post_rst_cnts", {o_frame_cnt, o_hit_cnt}, {16'd1, 16'd1});

      // saturation on the small instance (2-bit counters, 4-sample frames)
      starts = 0;
      for (int f = 0; f < 5; f++) begin
         for (int n = 0; n < 4; n++) begin
            s_bv = 1'b1; s_bd = 16'(n + 10 * f);
            s_tv = 1'b1; s_td = 16'(n + 50);
            tick();
         end
         s_bv = 1'b0; s_tv = 1'b0;
         t = 0;
         while (s_start !== 1'b1 && t < 20) begin tick(); t++; end
         if (s_start === 1'b1) starts++;
         if (f == 2) chk("small_sample0", {s_sig_base, s_sig_test}, {16'd20, 16'd50});
         repeat (5) tick();
         s_fin = 1'b1; s_res = 1'b1;
         tick();
         s_fin = 1'b0; s_res = 1'b0;
      end
      chk("small_starts", 32'(starts), 5);
      chk("small_frame_sat", 32'(s_frame_cnt), 3);
      chk("small_hit_sat", 32'(s_hit_cnt), 3);
      chk("small_ovf", 32'(s_ovf), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/score_frame_feeder.md
# score_frame_feeder

Capture-and-stream stage upstream of the scoring `evaluate` block. It collects reference ("base") and singer ("test") 16-bit samples into a ping-pong pair of frame buffers. When a frame is complete on both channels, it streams the frame to `evaluate` one sample pair per clock with a one-cycle start pulse. It then waits for the evaluator's finish/result and accumulates frame and hit counts for the score display.

## Interface
- `DATA_W`, 16, sample width of both channels
- `FRAME_LEN`, 256, samples per frame; power of two, ≥ 4
- `CNT_W`, 16, width of the frame and hit counters
- `i_clk`  in  1  single system clock; all logic is rising-edge
- `i_rst`  in  1  reset; asynchronous and active-high; clears all state
- `i_enable`  in  1  capture enable; when low, incoming valids are ignored (not counted as overflow)
- `i_base_valid`  in  1  `i_base_data` is valid this cycle
- `i_base_data`  in  DATA_W  reference sample
- `i_test_valid`  in  1  `i_test_data` is valid this cycle
- `i_test_data`  in  DATA_W  singer sample
- `o_start`  out  1  one-cycle pulse, coincident with sample 0 of a frame
- `o_stream_valid`  out  1  high for exactly FRAME_LEN cycles per frame, starting with the `o_start` cycle
- `o_signal_base`  out  DATA_W  streamed base sample
- `o_signal_test`  out  DATA_W  streamed test sample
- `i_eval_finish`  in  1  evaluator done (pulse)
- `i_eval_result`  in  1  evaluator verdict; sampled with `i_eval_finish`
- `o_frame_cnt`  out  CNT_W  frames evaluated; saturating
- `o_hit_cnt`  out  CNT_W  frames with result = 1; saturating
- `o_overflow`  out  1  sticky; a valid sample was dropped
- `o_busy`  out  1  stream FSM not in S_IDLE

## Operation
- **Capture side.**
  - Write bank `wr_bank` (0/1) and two independent write pointers `base_ptr` and `test_ptr` (0..FRAME_LEN).
  - A valid sample is written at its pointer address, and that pointer increments.
  - A channel whose pointer equals FRAME_LEN drops further samples and sets `o_overflow`.
  - When both pointers equal FRAME_LEN: set `full[wr_bank]`, toggle `wr_bank`, and clear both pointers, all on the same edge.
  - If `full[wr_bank]` is set (both banks occupied), all valids are dropped and `o_overflow` is set.
  - Simultaneous base and test valids are both accepted in the same cycle.
- **Stream FSM.** States S_IDLE, S_PREP, S_STREAM, S_WAIT. Read bank is `rd_bank`.
  - S_IDLE: if `full[rd_bank]`, go to S_PREP.
  - S_PREP: issue read address 0, then go to S_STREAM.
  - S_STREAM: outputs show sample `k` for k = 0..FRAME_LEN-1. `o_start` is high only at k = 0. Read address k+1 is issued each cycle. After k = FRAME_LEN-1, go to S_WAIT.
  - S_WAIT: on `i_eval_finish`, increment `o_frame_cnt`, add `i_eval_result` to `o_hit_cnt`, clear `full[rd_bank]`, toggle `rd_bank`, and go to S_IDLE.
- `i_eval_finish` outside S_WAIT is ignored.
- Counters saturate at 2^CNT_W − 1.
- `i_enable` low does not abort streaming or waiting.
- Outside S_STREAM, `o_signal_*` hold 0.

## Timing
- **Reset values.**
  - All outputs are 0.
  - `wr_bank` = `rd_bank` = 0, both `full` flags = 0, pointers = 0, FSM in S_IDLE.
  - Reset asserted mid-stream drops the frame immediately; `o_start` never re-fires for it.
- **Capture to start.** The completing sample is sampled at edge E0 (`full` set at E0). The FSM is in S_PREP after E1, and `o_start` is high in the cycle after E2. Latency is 2 cycles.
- **Stream length.** `o_stream_valid` is high for exactly FRAME_LEN consecutive cycles with no gaps.
- **Bank release.** The bank is released on the edge that samples `i_eval_finish`. If it was the blocked write bank, capture into it resumes on the next cycle's valids.
- **Back-to-back frames.** If the other bank is already full at release, the next `o_start` occurs 2 cycles after release (through S_IDLE and S_PREP). `i_eval_finish` in the same cycle as `o_start` is therefore impossible.
- **RAM.** Synchronous read, 1-cycle latency. A write and a read never target the same bank in the same cycle, by construction of the `full` flags.

## Structure
- Shared package `score_pkg`:
  - `DATA_W` and `FRAME_LEN` defaults, shared with `evaluate`.
  - Stream state enum (S_IDLE, S_PREP, S_STREAM, S_WAIT).
  - Sample type `logic [DATA_W-1:0]`.
- One sub-module, `frame_bank_ram`: simple dual-port memory of 2·FRAME_LEN words × 2·DATA_W, addressed by {bank, index}. It has a byte-lane style split write enable for the base half and the test half, and a registered read.
- Capture logic, stream FSM, and counters live in `score_frame_feeder`.

## Test plan
- **Single frame.** Feed 256 pairs (base = n, test = 1000+n), one per cycle, with `i_enable` = 1. Required: `o_start` 2 cycles after the last pair, outputs 0/1000 … 255/1255 over 256 cycles, `o_stream_valid` high for exactly 256 cycles. Then `i_eval_finish` = 1 with result = 1 → `o_frame_cnt` = 1, `o_hit_cnt` = 1.
- **Skewed channels.** Send 256 base samples first, then 256 test samples 100 cycles later. Required: `o_start` only after the 256th test sample; data in order; `o_overflow` = 0.
- **Ping-pong.** Send frame A, hold `i_eval_finish` low, then send frame B. Required: B is accepted with no overflow and streams 2 cycles after A's finish. A result = 0 and B result = 1 → frame = 2, hit = 1.
- **Overflow.** With both banks full and no finish, send 5 more samples. Required: `o_overflow` = 1 and stays 1; samples dropped; the later stream contains only the original data.
- **Reset mid-stream.** Assert `i_rst` at stream sample 100. Required: all outputs 0 immediately; no further `o_start` until a new full frame is captured.
- **Misc.** A stray `i_eval_finish` in S_IDLE leaves the counters unchanged. Forcing the counter near max with 3 extra frames saturates `o_frame_cnt` at 0xFFFF.
